cfg_stream_loader: RTL and testbench

//  Configuration bus master for the tile configuration port (cfg_a/cfg_d/cfg_en).

---
 rtl/cfg_pkg.sv | 9 +
 rtl/cfg_stream_loader.sv | 119 +++++++++++
 tb/tb_cfg_stream_loader.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cfg_pkg.sv
// Shared types and field positions for the configuration stream loader.
package cfg_pkg;
   typedef enum logic [1:0] {CFG_HDR, CFG_DATA, CFG_GAP, CFG_CSUM} cfg_ld_state_t;

   localparam int HDR_ADDR_LSB = 24;
   localparam int HDR_CNT_LSB  = 0;
   localparam int CFG_ADDR_W   = 8;
   localparam int CFG_DATA_W   = 32;
endpackage

// File: rtl/cfg_stream_loader.sv
// Framed bitstream -> tile config writes (header, N payload words, XOR checksum).
// Latency 1 from payload accept to cfg_en; bs_ready drops only during forced GAP cycles.
module cfg_stream_loader
   import cfg_pkg::*;
#(
   parameter int ADDR_W     = CFG_ADDR_W,
   parameter int DATA_W     = CFG_DATA_W,
   parameter int CNT_W      = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic              cfg_clk,
   input  logic              cfg_rst_n,
   input  logic              bs_valid,
   input  logic [DATA_W-1:0] bs_data,
   output logic              bs_ready,
   output logic [ADDR_W-1:0] cfg_a,
   output logic [DATA_W-1:0] cfg_d,
   output logic              cfg_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   cfg_ld_state_t     r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_remain;
   logic [DATA_W-1:0] r_csum;
   logic [3:0]        r_gap;
   logic              r_bs_ready;
   logic [ADDR_W-1:0] r_cfg_a;
   logic [DATA_W-1:0] r_cfg_d;
   logic              r_cfg_en;
   logic              r_busy;
   logic              r_done;
   logic              r_err;

   logic              w_xfer;
   logic [CNT_W-1:0]  w_hdr_cnt;

   assign w_xfer    = bs_valid & r_bs_ready;
   assign w_hdr_cnt = bs_data[HDR_CNT_LSB +: CNT_W];

   always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
      if (!cfg_rst_n) begin
         r_state    <= CFG_HDR;
         r_addr     <= '0;
         r_remain   <= '0;
         r_csum     <= '0;
         r_gap      <= '0;
         r_bs_ready <= 1'b0;
         r_cfg_a    <= '0;
         r_cfg_d    <= '0;
         r_cfg_en   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_cfg_en   <= 1'b0;
         r_bs_ready <= 1'b1;
         case (r_state)
            CFG_HDR: begin
               if (w_xfer) begin
                  r_addr   <= bs_data[HDR_ADDR_LSB +: ADDR_W];
                  r_remain <= w_hdr_cnt;
                  r_csum   <= bs_data;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
                  r_err    <= 1'b0;
                  r_state  <= (w_hdr_cnt == '0) ? CFG_CSUM : CFG_DATA;
               end
            end
            CFG_DATA: begin
               if (w_xfer) begin
                  r_cfg_en <= 1'b1;
                  r_cfg_a  <= r_addr;
                  r_cfg_d  <= bs_data;
                  r_addr   <= r_addr + ADDR_W'(1);
                  r_remain <= r_remain - CNT_W'(1);
                  r_csum   <= r_csum ^ bs_data;
                  if (GAP_CYCLES > 0) begin
                     r_state    <= CFG_GAP;
                     r_gap      <= 4'(GAP_CYCLES - 1);
                     r_bs_ready <= 1'b0;
                  end else begin
                     r_state <= (r_remain == CNT_W'(1)) ? CFG_CSUM : CFG_DATA;
                  end
               end
            end
            CFG_GAP: begin
               // r_remain was already decremented by the write that opened this gap
               if (r_gap == 4'd0) begin
                  r_state <= (r_remain == '0) ? CFG_CSUM : CFG_DATA;
               end else begin
                  r_gap      <= r_gap - 4'd1;
                  r_bs_ready <= 1'b0;
               end
            end
            CFG_CSUM: begin
               if (w_xfer) begin
                  r_done  <= (bs_data == r_csum);
                  r_err   <= (bs_data != r_csum);
                  r_busy  <= 1'b0;
                  r_state <= CFG_HDR;
               end
            end
            default: r_state <= CFG_HDR;
         endcase
      end
   end

   assign bs_ready = r_bs_ready;
   assign cfg_a    = r_cfg_a;
   assign cfg_d    = r_cfg_d;
   assign cfg_en   = r_cfg_en;
   assign busy     = r_busy;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench: frame table on a GAP_CYCLES=0 loader, plus gap, drop and reset sequences.
module tb_cfg_stream_loader;

   logic        clk;
   logic        rst_n;
   logic        v0, v2;
   logic [31:0] d0, d2;
   logic        rdy0, rdy2;
   logic [7:0]  a0, a2;
   logic [31:0] q0, q2;
   logic        en0, en2;
   logic        busy0, busy2;
   logic        done0, done2;
   logic        err0, err2;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   int rdy2_low = 0;

   int          qa0[$];
   logic [31:0] qd0[$];
   int          qc0[$];
   int          qa2[$];
   int          qc2[$];

   cfg_stream_loader #(.GAP_CYCLES(0)) u0 (
      .cfg_clk(clk), .cfg_rst_n(rst_n), .bs_valid(v0), .bs_data(d0), .bs_ready(rdy0),
      .cfg_a(a0), .cfg_d(q0), .cfg_en(en0), .busy(busy0), .done(done0), .err(err0));

   cfg_stream_loader #(.GAP_CYCLES(2)) u2 (
      .cfg_clk(clk), .cfg_rst_n(rst_n), .bs_valid(v2), .bs_data(d2), .bs_ready(rdy2),
      .cfg_a(a2), .cfg_d(q2), .cfg_en(en2), .busy(busy2), .done(done2), .err(err2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && en0) begin
         qa0.push_back(int'(a0));
         qd0.push_back(q0);
         qc0.push_back(cyc);
      end
      if (rst_n && en2) begin
         qa2.push_back(int'(a2));
         qc2.push_back(cyc);
      end
      if (rst_n && !rdy2) rdy2_low <= rdy2_low + 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Presents one word and returns #1 after the edge that transferred it.
   task automatic send(input int which, input logic [31:0] w);
      int  t;
      bit  got;
      t   = 0;
      got = 0;
      if (which == 0) begin v0 = 1'b1; d0 = w; end
      else            begin v2 = 1'b1; d2 = w; end
      while (!got && t < 50) begin
         @(negedge clk);
         got = (which == 0) ? rdy0 : rdy2;
         @(posedge clk);
         #1;
         t++;
      end
      if (!got) chk("send_timeout", 64'd0, 64'd1);
   endtask

   typedef struct packed {
      logic [31:0]      hdr;
      logic [15:0]      n;
      logic [3:0][31:0] d;
      logic [31:0]      csum_xor;
      logic [3:0][7:0]  exp_a;
      logic             exp_done;
      logic             exp_err;
      logic             drops;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] hdr, input logic [15:0] n,
                               input logic [31:0] w0, w1, w2, w3, input logic [31:0] cx,
                               input logic [7:0] e0, e1, e2, e3,
                               input logic dn, er, dr);
      vec_t r;
      r.hdr = hdr; r.n = n;
      r.d[0] = w0; r.d[1] = w1; r.d[2] = w2; r.d[3] = w3;
      r.csum_xor = cx;
      r.exp_a[0] = e0; r.exp_a[1] = e1; r.exp_a[2] = e2; r.exp_a[3] = e3;
      r.exp_done = dn; r.exp_err = er; r.drops = dr;
      return r;
   endfunction

   vec_t vecs[6];

   initial begin
      logic [31:0] cs;
      int          base;

      vecs[0] = mk(32'h1000_0003, 3, 32'hA5A5_0001, 32'h5A5A_0002, 32'hDEAD_BEEF, 0, 0,
                   8'h10, 8'h11, 8'h12, 8'h00, 1, 0, 0);
      vecs[1] = mk(32'hFE00_0004, 4, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 0,
                   8'hFE, 8'hFF, 8'h00, 8'h01, 1, 0, 0);
      vecs[2] = mk(32'h2000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[3] = mk(32'h2000_0000, 0, 0, 0, 0, 0, 32'h2000_0000, 0, 0, 0, 0, 0, 1, 0);
      vecs[4] = mk(32'h7F00_0003, 3, 32'h0BAD_F00D, 32'h1234_5678, 32'h8765_4321, 0, 0,
                   8'h7F, 8'h80, 8'h81, 8'h00, 1, 0, 1);
      vecs[5] = mk(32'h0155_0002, 2, 32'hFFFF_0000, 32'h0000_FFFF, 0, 0, 32'h0000_0001,
                   8'h01, 8'h02, 8'h00, 8'h00, 0, 1, 0);

      rst_n = 1'b0; v0 = 0; v2 = 0; d0 = 0; d2 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", rdy0, 0);
      chk("rst_cfg_en", en0, 0);
      chk("rst_cfg_a", a0, 0);
      chk("rst_cfg_d", q0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_done_err", {done0, err0}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_rst", rdy0, 1);

      // Frames 0 and 1 run back-to-back with valid held high throughout.
      for (int i = 0; i < 6; i++) begin
         qa0.delete(); qd0.delete(); qc0.delete();
         cs = vecs[i].hdr;
         if (vecs[i].drops) begin v0 = 0; repeat (2) @(posedge clk); #1; end
         send(0, vecs[i].hdr);
         chk($sformatf("v%0d_busy_hdr", i), busy0, 1);
         chk($sformatf("v%0d_done_clr", i), {done0, err0}, 0);
         for (int k = 0; k < int'(vecs[i].n); k++) begin
            if (vecs[i].drops) begin
               v0 = 0;
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            send(0, vecs[i].d[k]);
            cs = cs ^ vecs[i].d[k];
         end
         send(0, cs ^ vecs[i].csum_xor);
         if (vecs[i].drops || i >= 2) v0 = 0;
         chk($sformatf("v%0d_count", i), qa0.size(), vecs[i].n);
         for (int k = 0; k < qa0.size() && k < int'(vecs[i].n); k++) begin
            chk($sformatf("v%0d_a%0d", i, k), qa0[k], vecs[i].exp_a[k]);
            chk($sformatf("v%0d_d%0d", i, k), qd0[k], vecs[i].d[k]);
         end
         chk($sformatf("v%0d_done", i), done0, vecs[i].exp_done);
         chk($sformatf("v%0d_err", i), err0, vecs[i].exp_err);
         chk($sformatf("v%0d_busy_end", i), busy0, 0);
         if (i == 0 && qc0.size() == 3) begin
            chk("v0_consec1", qc0[1] - qc0[0], 1);
            chk("v0_consec2", qc0[2] - qc0[1], 1);
         end
         if (vecs[i].n != 0) chk($sformatf("v%0d_hold_a", i), a0, vecs[i].exp_a[vecs[i].n - 1]);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("idle_no_spurious", qa0.size(), 2);

      // Forced gap of 2 cycles after every write.
      qa2.delete(); qc2.delete();
      rdy2_low = 0;
      cs = 32'h5000_0003;
      send(2, 32'h5000_0003);
      for (int k = 0; k < 3; k++) begin
         send(2, 32'h100 + k);
         cs = cs ^ (32'h100 + k);
      end
      send(2, cs);
      v2 = 0;
      chk("gap_count", qa2.size(), 3);
      if (qa2.size() == 3) begin
         chk("gap_a0", qa2[0], 8'h50);
         chk("gap_a2", qa2[2], 8'h52);
         chk("gap_space1", qc2[1] - qc2[0], 3);
         chk("gap_space2", qc2[2] - qc2[1], 3);
      end
      chk("gap_ready_low", rdy2_low, 6);
      chk("gap_done", {done2, err2}, 2'b10);

      // Reset in the middle of a 5-word frame.
      qa0.delete();
      send(0, 32'h3000_0005);
      send(0, 32'hAAAA_0000);
      send(0, 32'hAAAA_0001);
      chk("mid_en_before_rst", en0, 1);
      rst_n = 1'b0;
      v0 = 0;
      #1;
      chk("arst_cfg_en", en0, 0);
      chk("arst_cfg_a", a0, 0);
      chk("arst_cfg_d", q0, 0);
      chk("arst_ready", rdy0, 0);
      chk("arst_busy", busy0, 0);
      chk("arst_done", done0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      qa0.delete(); qd0.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_no_en", qa0.size(), 0);
      send(0, 32'h4000_0001);
      send(0, 32'hCAFE_F00D);
      send(0, 32'h4000_0001 ^ 32'hCAFE_F00D);
      v0 = 0;
      chk("fresh_count", qa0.size(), 1);
      if (qa0.size() == 1) begin
         chk("fresh_a", qa0[0], 8'h40);
         chk("fresh_d", qd0[0], 32'hCAFE_F00D);
      end
      chk("fresh_done", {done0, err0}, 2'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
